dotprod_host: RTL

DOTPROD_HOST -- requirements
Module: dotprod_host

---
 rtl/dotprod_host.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dotprod_host.sv
// Host launcher for an ap_ctrl_hs dot-product kernel, plus two preloadable
// single-port memory banks that the kernel reads and writes.

module dotprod_host_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic [31:0]   address0,
  input  logic [31:0]   ad0,
  input  logic          ce0,
  input  logic          we0,
  output logic [31:0]   q0
);
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   q0_q;
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          k_wr_s;
  logic          k_rd_s;
  logic          ld_hit_s;

  // Address decode: any bit above the index range turns the access into a no-op.
  always_comb begin
    idx_s      = address0[AW-1:0];
    in_range_s = (address0[31:AW] == {(32-AW){1'b0}});
    k_wr_s     = ce0 & we0 & in_range_s;
    k_rd_s     = ce0 & ~we0;
    ld_hit_s   = ld_we & (ld_addr == idx_s);
  end

  // Storage update; a preload to the same word suppresses the kernel write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: 32'd0};
    end else begin
      if (k_wr_s && !ld_hit_s) begin
        mem_q[idx_s] <= ad0;
      end
      if (ld_we) begin
        mem_q[ld_addr] <= ld_data;
      end
    end
  end

  // Read port samples pre-edge contents, so same-cycle writes are not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_q <= 32'd0;
    end else if (k_rd_s) begin
      q0_q <= in_range_s ? mem_q[idx_s] : 32'd0;
    end
  end

  assign q0 = q0_q;
endmodule

module dotprod_host #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     cmd_start,
  input  logic [31:0]              cmd_n,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     timeout,
  output logic [31:0]              result,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     k_ap_start,
  output logic [31:0]              k_n,
  input  logic                     k_ap_idle,
  input  logic                     k_ap_ready,
  input  logic                     k_ap_done,
  input  logic [31:0]              k_ap_return,
  input  logic [31:0]              a_address0,
  input  logic [31:0]              a_ad0,
  input  logic                     a_ce0,
  input  logic                     a_we0,
  output logic [31:0]              a_q0,
  input  logic [31:0]              b_address0,
  input  logic [31:0]              b_ad0,
  input  logic                     b_ce0,
  input  logic                     b_we0,
  output logic [31:0]              b_q0
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_RUN    = 5'b00100,
    S_DONE   = 5'b01000,
    S_TOUT   = 5'b10000
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] k_n_q;
  logic [31:0] result_q;
  logic        busy_q;
  logic        result_valid_q;
  logic        timeout_q;
  logic        k_ap_start_q;
  logic        cnt_last_s;
  logic        ld_we_a_s;
  logic        ld_we_b_s;

  // Timeout compare and preload gating (preloads only land while idle).
  always_comb begin
    cnt_last_s = (cnt_q >= CNT_LAST);
    ld_we_a_s  = ld_en & ~busy_q & ~ld_sel;
    ld_we_b_s  = ld_en & ~busy_q & ld_sel;
  end

  // Launch/complete sequencer; every status output is registered here.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 32'd0;
      k_n_q          <= 32'd0;
      result_q       <= 32'd0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      k_ap_start_q   <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start && k_ap_idle) begin
            state_q      <= S_LAUNCH;
            k_n_q        <= cmd_n;
            cnt_q        <= 32'd0;
            busy_q       <= 1'b1;
            k_ap_start_q <= 1'b1;
          end
        end
        S_LAUNCH: begin
          cnt_q <= cnt_q + 32'd1;
          if (k_ap_ready && k_ap_done) begin
            state_q        <= S_DONE;
            result_q       <= k_ap_return;
            result_valid_q <= 1'b1;
            k_ap_start_q   <= 1'b0;
          end else if (cnt_last_s) begin
            state_q      <= S_TOUT;
            timeout_q    <= 1'b1;
            k_ap_start_q <= 1'b0;
          end else if (k_ap_ready) begin
            state_q      <= S_RUN;
            k_ap_start_q <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 32'd1;
          // A completion in the expiry cycle still counts as success.
          if (k_ap_done) begin
            state_q        <= S_DONE;
            result_q       <= k_ap_return;
            result_valid_q <= 1'b1;
          end else if (cnt_last_s) begin
            state_q   <= S_TOUT;
            timeout_q <= 1'b1;
          end
        end
        S_DONE, S_TOUT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          k_ap_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign result       = result_q;
  assign k_ap_start   = k_ap_start_q;
  assign k_n          = k_n_q;

  dotprod_host_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank_a (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .ld_we    (ld_we_a_s),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .address0 (a_address0),
    .ad0      (a_ad0),
    .ce0      (a_ce0),
    .we0      (a_we0),
    .q0       (a_q0)
  );

  dotprod_host_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank_b (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .ld_we    (ld_we_b_s),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .address0 (b_address0),
    .ad0      (b_ad0),
    .ce0      (b_ce0),
    .we0      (b_we0),
    .q0       (b_q0)
  );
endmodule
